// File: rtl/serial_add_sub_pkg.sv
// Shared types and elaboration helpers for the slice-serial adder/subtractor.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    function automatic int unsigned num_slices(input int unsigned width, input int unsigned slice);
        return width / slice;
    endfunction

    // Counter must be able to hold N itself.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned slice);
        return (slice != 0) && (width >= 2) && (width % slice == 0);
    endfunction

endpackage

// File: rtl/ripple_slice.sv
// Combinational SLICE-bit ripple-carry adder; also exposes the carry into the top bit.
module ripple_slice #(
    parameter int unsigned SLICE = 1
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [SLICE:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < int'(SLICE); i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign cout  = c[SLICE];
    assign c_msb = c[SLICE-1];

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed SLICE bits per clock, LSB first,
// with a start/busy/done handshake and registered sum, carry and signed overflow.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);

    localparam int unsigned N    = num_slices(WIDTH, SLICE);
    localparam int unsigned CntW = cnt_width(N);

    if (!params_ok(WIDTH, SLICE)) begin : g_param_check
        $error("serial_add_sub: WIDTH must be >= 2 and a multiple of SLICE");
    end

    state_e            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  s_q;
    logic              c_q;
    logic              co_q;
    logic              ov_q;
    logic              busy_q;
    logic              done_q;
    logic [CntW-1:0]   cnt_q;

    logic [SLICE-1:0]       slice_sum;
    logic                   slice_cout;
    logic                   slice_c_msb;
    logic [WIDTH+SLICE-1:0] s_cat;
    logic                   last;

    ripple_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .x     (a_q[SLICE-1:0]),
        .y     (b_q[SLICE-1:0]),
        .cin   (c_q),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c_msb (slice_c_msb)
    );

    // New slice enters at the MSB end; also well-formed when SLICE == WIDTH.
    assign s_cat = {slice_sum, s_q};
    assign last  = (cnt_q == CntW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        // Subtraction as A + ~B + ~borrow.
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        c_q     <= sub ? ~ci : ci;
                        s_q     <= '0;
                        co_q    <= 1'b0;
                        ov_q    <= 1'b0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    s_q   <= s_cat[WIDTH+SLICE-1:SLICE];
                    a_q   <= a_q >> SLICE;
                    b_q   <= b_q >> SLICE;
                    c_q   <= slice_cout;
                    cnt_q <= cnt_q + CntW'(1);
                    if (last) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        co_q    <= slice_cout;
                        ov_q    <= slice_cout ^ slice_c_msb;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign co   = co_q;
    assign ov   = ov_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: four configurations checked every cycle against an arithmetic model.
module tb_serial_add_sub;

    localparam int NN [4] = '{8, 4, 4, 1};
    localparam int WW [4] = '{8, 8, 4, 4};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a_bus = '0;
    logic [7:0] b_bus = '0;
    logic       ci_r = 1'b0;
    logic       sub_r = 1'b0;
    logic [3:0] start_v = '0;
    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [3:0] co_v;
    logic [3:0] ov_v;
    logic [7:0] s0, s1;
    logic [3:0] s2, s3;
    logic [7:0] s_v [4];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cyc = 0;

    int         m_acc [4] = '{-1, -1, -1, -1};
    logic [7:0] m_s   [4] = '{8'h0, 8'h0, 8'h0, 8'h0};
    logic       m_co  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic       m_ov  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(8), .SLICE(1)) u_d0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_bus), .b(b_bus), .ci(ci_r), .sub(sub_r),
        .busy(busy_v[0]), .done(done_v[0]), .s(s0), .co(co_v[0]), .ov(ov_v[0])
    );
    serial_add_sub #(.WIDTH(8), .SLICE(2)) u_d1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_bus), .b(b_bus), .ci(ci_r), .sub(sub_r),
        .busy(busy_v[1]), .done(done_v[1]), .s(s1), .co(co_v[1]), .ov(ov_v[1])
    );
    serial_add_sub #(.WIDTH(4), .SLICE(1)) u_d2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_bus[3:0]), .b(b_bus[3:0]), .ci(ci_r),
        .sub(sub_r), .busy(busy_v[2]), .done(done_v[2]), .s(s2), .co(co_v[2]), .ov(ov_v[2])
    );
    serial_add_sub #(.WIDTH(4), .SLICE(4)) u_d3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .a(a_bus[3:0]), .b(b_bus[3:0]), .ci(ci_r),
        .sub(sub_r), .busy(busy_v[3]), .done(done_v[3]), .s(s3), .co(co_v[3]), .ov(ov_v[3])
    );

    always_comb begin
        s_v[0] = s0;
        s_v[1] = s1;
        s_v[2] = {4'h0, s2};
        s_v[3] = {4'h0, s3};
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic: returns {ov, co, s}.
    function automatic logic [9:0] ref_calc(input int w, input logic [7:0] av, input logic [7:0] bv,
                                            input logic civ, input logic subv);
        int full, half, ua, ub, sa, sb, ru, rs, sm;
        logic co_e, ov_e;
        logic [7:0] s_e;
        full = 1 << w;
        half = full / 2;
        ua   = int'(av) % full;
        ub   = int'(bv) % full;
        sa   = (ua >= half) ? ua - full : ua;
        sb   = (ub >= half) ? ub - full : ub;
        ru   = subv ? ua - ub - int'(civ) : ua + ub + int'(civ);
        rs   = subv ? sa - sb - int'(civ) : sa + sb + int'(civ);
        co_e = subv ? (ru >= 0) : (ru >= full);
        ov_e = (rs < -half) || (rs >= half);
        sm   = (ru + 2 * full) % full;
        s_e  = sm[7:0];
        return {ov_e, co_e, s_e};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Model: acceptance when start is high and the previous op's busy window is over.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_acc[i] <= -1;
                m_s[i]   <= '0;
                m_co[i]  <= 1'b0;
                m_ov[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (start_v[i] && !(m_acc[i] >= 0 && cyc >= m_acc[i] && cyc < m_acc[i] + NN[i]))
                begin
                    logic [9:0] r;
                    r = ref_calc(WW[i], a_bus, b_bus, ci_r, sub_r);
                    m_acc[i] <= cyc + 1;
                    m_s[i]   <= r[7:0];
                    m_co[i]  <= r[8];
                    m_ov[i]  <= r[9];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            logic eb, ed;
            eb = (m_acc[i] >= 0) && (cyc >= m_acc[i]) && (cyc < m_acc[i] + NN[i]);
            ed = (m_acc[i] >= 0) && (cyc == m_acc[i] + NN[i]);
            check($sformatf("u%0d busy", i), int'(busy_v[i]), int'(eb));
            check($sformatf("u%0d done", i), int'(done_v[i]), int'(ed));
            if (m_acc[i] < 0 || cyc >= m_acc[i] + NN[i]) begin
                check($sformatf("u%0d s", i), int'(s_v[i]), int'(m_s[i]));
                check($sformatf("u%0d co", i), int'(co_v[i]), int'(m_co[i]));
                check($sformatf("u%0d ov", i), int'(ov_v[i]), int'(m_ov[i]));
            end
        end
    end

    task automatic run_op(input int i, input logic [7:0] av, input logic [7:0] bv,
                          input logic civ, input logic subv);
        @(negedge clk);
        a_bus      = av;
        b_bus      = bv;
        ci_r       = civ;
        sub_r      = subv;
        start_v[i] = 1'b1;
        @(posedge clk);
        #1 start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int nbusy);
        bit seen;
        nbusy = 0;
        seen  = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done_v[i]) seen = 1;
            else if (busy_v[i]) nbusy++;
        end
        done_cyc = cyc;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL u%0d done timeout: got no done, expected done within 40 cycles", i);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no end of test, expected finish before 3000000");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, first;
        repeat (2) @(negedge clk);
        check("reset s", int'(s0), 0);
        check("reset busy", int'(busy_v), 0);
        check("reset done", int'(done_v), 0);
        rst = 1'b0;

        // 0x7F + 0x01: positive overflow
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0);
        wait_done(0, nb);
        check("add busy cycles", nb, 8);
        check("add s", int'(s0), 'h80);
        check("add co", int'(co_v[0]), 0);
        check("add ov", int'(ov_v[0]), 1);

        // SLICE=2 subtraction: borrow, then negative overflow
        run_op(1, 8'h00, 8'h01, 1'b0, 1'b1);
        wait_done(1, nb);
        check("sub busy cycles", nb, 4);
        check("sub s", int'(s1), 'hFF);
        check("sub co", int'(co_v[1]), 0);
        check("sub ov", int'(ov_v[1]), 0);
        run_op(1, 8'h80, 8'h01, 1'b0, 1'b1);
        wait_done(1, nb);
        check("sub2 s", int'(s1), 'h7F);
        check("sub2 co", int'(co_v[1]), 1);
        check("sub2 ov", int'(ov_v[1]), 1);

        // SLICE == WIDTH: single-cycle operation
        run_op(3, 8'h09, 8'h08, 1'b0, 1'b0);
        wait_done(3, nb);
        check("w4s4 busy cycles", nb, 1);
        check("w4s4 s", int'(s3), 'h1);
        check("w4s4 co", int'(co_v[3]), 1);
        check("w4s4 ov", int'(ov_v[3]), 1);

        // Start during RUN must be ignored.
        run_op(0, 8'hFF, 8'h01, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        a_bus = 8'h12; b_bus = 8'h34; ci_r = 1'b0; sub_r = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, nb);
        check("ignore s", int'(s0), 'h01);
        check("ignore co", int'(co_v[0]), 1);
        check("ignore ov", int'(ov_v[0]), 0);

        // Asynchronous reset mid-operation.
        run_op(0, 8'h55, 8'h66, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst s", int'(s0), 0);
        check("midrst co", int'(co_v[0]), 0);
        check("midrst ov", int'(ov_v[0]), 0);
        check("midrst busy", int'(busy_v[0]), 0);
        check("midrst done", int'(done_v[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(0, 8'h12, 8'h34, 1'b0, 1'b0);
        wait_done(0, nb);
        check("postrst s", int'(s0), 'h46);

        // Back-to-back: start held through the DONE cycle.
        @(negedge clk);
        a_bus = 8'h10; b_bus = 8'h20; ci_r = 1'b0; sub_r = 1'b0;
        start_v[1] = 1'b1;
        wait_done(1, nb);
        first = done_cyc;
        check("b2b first s", int'(s1), 'h30);
        a_bus = 8'h05; b_bus = 8'h03; sub_r = 1'b1;
        @(posedge clk);
        #1 start_v[1] = 1'b0;
        wait_done(1, nb);
        check("b2b spacing", done_cyc - first, 5);
        check("b2b second s", int'(s1), 'h02);
        check("b2b second co", int'(co_v[1]), 1);

        // Exhaustive 4-bit sweep on both 4-bit instances, checked by the model.
        for (int sb = 0; sb < 2; sb++) begin
            for (int cb = 0; cb < 2; cb++) begin
                for (int av = 0; av < 16; av++) begin
                    for (int bv = 0; bv < 16; bv++) begin
                        @(negedge clk);
                        a_bus = 8'(av); b_bus = 8'(bv); ci_r = cb[0]; sub_r = sb[0];
                        start_v[2] = 1'b1;
                        start_v[3] = 1'b1;
                        @(posedge clk);
                        #1;
                        start_v[2] = 1'b0;
                        start_v[3] = 1'b0;
                        wait_done(2, nb);
                    end
                end
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Parametrised multi-cycle adder/subtractor. It processes two WIDTH-bit operands SLICE bits per clock, LSB slice first, through a single SLICE-bit ripple carry slice. It uses a start/busy/done handshake and reports sum, carry and signed overflow. It is the sequential, width-generic successor to the single-bit full adder cell, for datapaths where one wide combinational carry chain is too long or too large.

## Interface
Parameters:
- WIDTH, 8: operand and result width in bits; must be ≥ 2.
- SLICE, 1: bits processed per cycle; must divide WIDTH. N = WIDTH/SLICE cycles per operation.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- start  in  1  request; accepted when busy = 0.
- a  in  WIDTH  operand A, sampled on the accepting edge.
- b  in  WIDTH  operand B, sampled on the accepting edge.
- ci  in  1  carry-in (add) or borrow-in (sub), sampled on the accepting edge.
- sub  in  1  0: s = a + b + ci. 1: s = a − b − ci. Sampled on the accepting edge.
- busy  out  1  operation in progress; start is ignored while high.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- s  out  WIDTH  result, modulo 2^WIDTH.
- co  out  1  carry out of the MSB. In sub mode, 1 means no borrow.
- ov  out  1  signed two's-complement overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → RUN.
  - RUN: after the N-th slice → DONE.
  - DONE: lasts one cycle. start=1 → RUN, otherwise → IDLE.
- Acceptance: start=1 in IDLE or DONE captures the operands.
  - Captured values: a, effective B = sub ? ~b : b, effective carry = sub ? ~ci : ci.
  - Operand shift registers and the running carry are loaded.
  - The result register is cleared.
- RUN: each cycle adds the low SLICE bits of A and effective B plus the running carry, using ripple_slice.
  - The sum slice is shifted into s from the MSB end.
  - The operand registers shift right by SLICE.
  - The carry register is updated.
- Final slice: records carry-in to MSB XOR carry-out of MSB as ov, and the final carry as co.
- Results: s, co and ov hold their values until the next acceptance or reset.
- Arithmetic: s = (A + B_eff + c_eff) mod 2^WIDTH. co is bit WIDTH of the full sum.
- Simultaneous events:
  - start while busy=1: ignored; no effect on the operation.
  - start during the DONE cycle: accepted. done still pulses in that cycle and busy rises on the next edge.
  - Input changes after acceptance: no effect.
- Reset, including mid-operation: immediately IDLE. busy=0, done=0, s=0, co=0, ov=0, all internal registers cleared. No partial result is retained.

## Timing
- All outputs are registered. Reset values are all 0.
- Accepting edge E0: busy=1 after E0.
- Slices are computed at edges E1..EN.
- After EN: busy=0, done=1, and s/co/ov are valid.
- Latency: N clock cycles from the accepting edge to done.
- Throughput: one operation per N+1 cycles. Back-to-back operation is possible by asserting start in the DONE cycle.
- busy is high for exactly N cycles per operation.

## Structure
- Shared package serial_add_sub_pkg:
  - FSM state enum (IDLE, RUN, DONE).
  - Constant function computing N = WIDTH/SLICE.
  - Counter width as clog2(N+1).
  - Elaboration check that WIDTH % SLICE == 0.
- One sub-module, ripple_slice: combinational SLICE-bit ripple adder with inputs x, y, cin and outputs sum, cout, and c_msb (carry into the top bit, used for ov).
- Top level holds the FSM, slice counter, operand shift registers, carry register and result register.

## Test plan
- WIDTH=8, SLICE=1, add: a=0x7F, b=0x01, ci=0 → after 8 cycles done=1, s=0x80, co=0, ov=1; busy high exactly 8 cycles.
- WIDTH=8, SLICE=2, sub: a=0x00, b=0x01, ci=0 → after 4 cycles s=0xFF, co=0 (borrow), ov=0. Then a=0x80, b=0x01 → s=0x7F, co=1, ov=1.
- WIDTH=4, SLICE=1 and SLICE=4: exhaustive a, b, ci, sub (1024 cases) → s/co/ov match the reference model. SLICE=4 gives done 1 cycle after acceptance.
- WIDTH=8, SLICE=1: start asserted again 3 cycles into RUN with different operands → ignored; the original result 0xFF+0x01+1 gives s=0x01, co=1.
- Reset mid-operation: rst pulsed at cycle 4 of 8 → s=0, co=0, ov=0, busy=0, done=0 immediately. A subsequent start completes normally.
- Back-to-back: start held high through the DONE cycle with new operands → second operation accepted, second done exactly N+1 cycles after the first.
